id_ex_ctrl_stage: RTL and testbench

Registered decode/control stage of the 5-stage RV32 pipeline. It sits between the IF/ID register and EX and performs full RV32I decode: all six branch types, load/store access sizes, a real ALU operation code and illegal-instruction flagging. The decoded bundle is held in the ID/EX register under a valid/ready handshake, with flush support. Load-use hazards are detected internally and resolved by a one-bubble interlock.

---
 rtl/id_ex_ctrl_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_id_ex_ctrl_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage: RV32I decode plus ID/EX control register with valid/ready
// handshake, flush and a one-bubble load-use interlock.
// Optional feature macro: CTRL_RV32M_EN (decodes the M-extension on opcode OP).
module id_ex_ctrl_stage #(
   parameter int unsigned PC_W       = 32,
   parameter int unsigned ALU_CTRL_W = 5,
   parameter int unsigned ILL_CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  id_valid,
   input  logic [31:0]           id_inst,
   input  logic [PC_W-1:0]       id_pc,
   output logic                  id_ready,
   input  logic                  ex_ready,
   input  logic                  flush,
   output logic                  ex_valid,
   output logic [PC_W-1:0]       ex_pc,
   output logic [31:0]           ex_inst,
   output logic [4:0]            ex_rs1,
   output logic [4:0]            ex_rs2,
   output logic [4:0]            ex_rd,
   output logic                  ex_rf_re0,
   output logic                  ex_rf_re1,
   output logic                  ex_jal,
   output logic                  ex_jalr,
   output logic [2:0]            ex_br_type,
   output logic                  ex_wb_en,
   output logic [1:0]            ex_wb_sel,
   output logic                  ex_alu_op1_sel,
   output logic                  ex_alu_op2_sel,
   output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
   output logic [2:0]            ex_imm_type,
   output logic                  ex_mem_we,
   output logic                  ex_mem_re,
   output logic [2:0]            ex_mem_size,
   output logic                  ex_illegal,
   output logic                  load_use_stall,
   output logic [ILL_CNT_W-1:0]  illegal_cnt
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] IMM_I = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_S = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;
   localparam logic [2:0] IMM_U = 3'b101;

   // Base ALU code from funct3; alt selects sub/sra.
   function automatic logic [ALU_CTRL_W-1:0] alu_code(input logic [2:0] f3, input logic alt);
      logic [3:0] c;
      case (f3)
         3'b000:  c = alt ? 4'd1 : 4'd0;
         3'b001:  c = 4'd2;
         3'b010:  c = 4'd3;
         3'b011:  c = 4'd4;
         3'b100:  c = 4'd5;
         3'b101:  c = alt ? 4'd7 : 4'd6;
         3'b110:  c = 4'd8;
         default: c = 4'd9;
      endcase
      return ALU_CTRL_W'(c);
   endfunction

   logic [6:0] w_opcode, w_f7;
   logic [2:0] w_f3;
   logic [4:0] w_rs1, w_rs2, w_rd;
   logic       w_use_rs1, w_use_rs2, w_rf_re0, w_rf_re1;
   logic       w_jal, w_jalr, w_wb_en, w_op1, w_op2, w_mem_we, w_mem_re, w_illegal;
   logic [2:0] w_br, w_imm, w_size;
   logic [1:0] w_wb_sel;
   logic [ALU_CTRL_W-1:0] w_alu;
   logic       w_hz, w_advance, w_load;

   assign w_opcode = id_inst[6:0];
   assign w_rd     = id_inst[11:7];
   assign w_f3     = id_inst[14:12];
   assign w_rs1    = id_inst[19:15];
   assign w_rs2    = id_inst[24:20];
   assign w_f7     = id_inst[31:25];

   // Combinational decode of the ID instruction, illegal encodings squash side effects.
   always_comb begin
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_jal     = 1'b0;
      w_jalr    = 1'b0;
      w_br      = 3'b000;
      w_wb_en   = 1'b0;
      w_wb_sel  = 2'b00;
      w_op1     = 1'b0;
      w_op2     = 1'b0;
      w_alu     = '0;
      w_imm     = 3'b000;
      w_mem_we  = 1'b0;
      w_mem_re  = 1'b0;
      w_size    = 3'b000;
      w_illegal = 1'b0;
      case (w_opcode)
         OP_LUI: begin
            w_wb_en = 1'b1; w_wb_sel = 2'b11; w_op2 = 1'b1; w_imm = IMM_U;
         end
         OP_AUIPC: begin
            w_wb_en = 1'b1; w_op1 = 1'b1; w_op2 = 1'b1; w_imm = IMM_U;
         end
         OP_JAL: begin
            w_jal = 1'b1; w_wb_en = 1'b1; w_wb_sel = 2'b01;
            w_op1 = 1'b1; w_op2 = 1'b1; w_imm = IMM_J;
         end
         OP_JALR: begin
            w_jalr = 1'b1; w_use_rs1 = 1'b1; w_wb_en = 1'b1; w_wb_sel = 2'b01;
            w_op2 = 1'b1; w_imm = IMM_I;
         end
         OP_BRANCH: begin
            w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_op1 = 1'b1; w_op2 = 1'b1; w_imm = IMM_B;
            case (w_f3)
               3'b000:  w_br = 3'b001;
               3'b001:  w_br = 3'b010;
               3'b100:  w_br = 3'b011;
               3'b101:  w_br = 3'b100;
               3'b110:  w_br = 3'b101;
               3'b111:  w_br = 3'b110;
               default: w_illegal = 1'b1;
            endcase
         end
         OP_LOAD: begin
            w_use_rs1 = 1'b1; w_mem_re = 1'b1; w_wb_en = 1'b1; w_wb_sel = 2'b10;
            w_op2 = 1'b1; w_imm = IMM_I; w_size = w_f3;
            w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         OP_STORE: begin
            w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_mem_we = 1'b1;
            w_op2 = 1'b1; w_imm = IMM_S; w_size = w_f3;
            w_illegal = (w_f3 > 3'b010);
         end
         OP_IMM: begin
            w_use_rs1 = 1'b1; w_wb_en = 1'b1; w_op2 = 1'b1; w_imm = IMM_I;
            w_alu = alu_code(w_f3, (w_f3 == 3'b101) && w_f7[5]);
            if (w_f3 == 3'b001)
               w_illegal = (w_f7 != 7'b0000000);
            else if (w_f3 == 3'b101)
               w_illegal = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
         end
         OP_REG: begin
            w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_wb_en = 1'b1;
            if (w_f7 == 7'b0000000)
               w_alu = alu_code(w_f3, 1'b0);
            else if ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))
               w_alu = alu_code(w_f3, 1'b1);
`ifdef CTRL_RV32M_EN
            else if (w_f7 == 7'b0000001)
               w_alu = ALU_CTRL_W'(5'd16 + {2'b00, w_f3});
`endif
            else
               w_illegal = 1'b1;
         end
         OP_FENCE, OP_SYSTEM: ;
         default: w_illegal = 1'b1;
      endcase
      w_wb_en = w_wb_en && (w_rd != 5'd0);
      if (w_illegal) begin
         w_wb_en  = 1'b0;
         w_mem_we = 1'b0;
         w_mem_re = 1'b0;
         w_jal    = 1'b0;
         w_jalr   = 1'b0;
         w_br     = 3'b000;
      end
   end

   assign w_rf_re0 = w_use_rs1 && (w_rs1 != 5'd0);
   assign w_rf_re1 = w_use_rs2 && (w_rs2 != 5'd0);

   // Load-use interlock and handshake.
   assign w_hz = ex_valid && ex_mem_re && ex_wb_en && id_valid &&
                 ((w_rf_re0 && (w_rs1 == ex_rd)) || (w_rf_re1 && (w_rs2 == ex_rd)));
   assign w_advance      = ex_ready || !ex_valid;
   assign w_load         = !flush && w_advance && id_valid && !w_hz;
   assign id_ready       = flush || (w_advance && !w_hz);
   assign load_use_stall = w_hz && !flush;

   // ID/EX register: flush/bubble, load, or hold.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ex_valid <= 1'b0; ex_pc <= '0; ex_inst <= '0;
         ex_rs1 <= '0; ex_rs2 <= '0; ex_rd <= '0;
         ex_rf_re0 <= 1'b0; ex_rf_re1 <= 1'b0; ex_jal <= 1'b0; ex_jalr <= 1'b0;
         ex_br_type <= '0; ex_wb_en <= 1'b0; ex_wb_sel <= '0;
         ex_alu_op1_sel <= 1'b0; ex_alu_op2_sel <= 1'b0; ex_alu_ctrl <= '0;
         ex_imm_type <= '0; ex_mem_we <= 1'b0; ex_mem_re <= 1'b0;
         ex_mem_size <= '0; ex_illegal <= 1'b0;
      end else if (w_load) begin
         ex_valid <= 1'b1; ex_pc <= id_pc; ex_inst <= id_inst;
         ex_rs1 <= w_rs1; ex_rs2 <= w_rs2; ex_rd <= w_rd;
         ex_rf_re0 <= w_rf_re0; ex_rf_re1 <= w_rf_re1; ex_jal <= w_jal; ex_jalr <= w_jalr;
         ex_br_type <= w_br; ex_wb_en <= w_wb_en; ex_wb_sel <= w_wb_sel;
         ex_alu_op1_sel <= w_op1; ex_alu_op2_sel <= w_op2; ex_alu_ctrl <= w_alu;
         ex_imm_type <= w_imm; ex_mem_we <= w_mem_we; ex_mem_re <= w_mem_re;
         ex_mem_size <= w_size; ex_illegal <= w_illegal;
      end else if (flush || w_advance) begin
         ex_valid <= 1'b0; ex_wb_en <= 1'b0; ex_mem_we <= 1'b0; ex_mem_re <= 1'b0;
         ex_jal <= 1'b0; ex_jalr <= 1'b0; ex_br_type <= '0; ex_illegal <= 1'b0;
      end
   end

   logic [ILL_CNT_W-1:0] r_ill_cnt;

   // Saturating count of illegal instructions entering EX.
   always_ff @(posedge clk) begin
      if (!rstn)
         r_ill_cnt <= '0;
      else if (w_load && w_illegal && (r_ill_cnt != '1))
         r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
   end

   assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Scoreboard bench for id_ex_ctrl_stage: expected bundles are queued on ID
// acceptance and checked when EX consumes them; handshake corners checked directly.
module tb_id_ex_ctrl_stage;

   logic        clk = 1'b0;
   logic        rstn, id_valid, ex_ready, flush;
   logic [31:0] id_inst, id_pc;
   logic        id_ready, ex_valid;
   logic [31:0] ex_pc, ex_inst;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl;
   logic        ex_rf_re0, ex_rf_re1, ex_jal, ex_jalr, ex_wb_en;
   logic [2:0]  ex_br_type, ex_imm_type, ex_mem_size;
   logic [1:0]  ex_wb_sel;
   logic        ex_alu_op1_sel, ex_alu_op2_sel, ex_mem_we, ex_mem_re, ex_illegal;
   logic        load_use_stall;
   logic [7:0]  illegal_cnt;

   id_ex_ctrl_stage dut (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_rf_re0(ex_rf_re0), .ex_rf_re1(ex_rf_re1), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
      .ex_br_type(ex_br_type), .ex_wb_en(ex_wb_en), .ex_wb_sel(ex_wb_sel),
      .ex_alu_op1_sel(ex_alu_op1_sel), .ex_alu_op2_sel(ex_alu_op2_sel),
      .ex_alu_ctrl(ex_alu_ctrl), .ex_imm_type(ex_imm_type), .ex_mem_we(ex_mem_we),
      .ex_mem_re(ex_mem_re), .ex_mem_size(ex_mem_size), .ex_illegal(ex_illegal),
      .load_use_stall(load_use_stall), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, inst;
      logic [4:0]  rd, alu;
      logic [2:0]  imm, br, size;
      logic [1:0]  wbsel;
      logic        wb, op1, op2, jal, jalr, mre, mwe, ill, full;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        cur_exp, mon_e;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] pc_ctr = 32'h100;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] alu, input logic wb, input logic [1:0] wbsel,
                               input logic op1, input logic op2, input logic [2:0] imm,
                               input logic [2:0] br, input logic jal, input logic jalr,
                               input logic mre, input logic mwe, input logic [2:0] size,
                               input logic ill, input logic full);
      exp_t e;
      e.pc = '0; e.inst = '0; e.rd = '0;
      e.alu = alu; e.wb = wb; e.wbsel = wbsel; e.op1 = op1; e.op2 = op2; e.imm = imm;
      e.br = br; e.jal = jal; e.jalr = jalr; e.mre = mre; e.mwe = mwe; e.size = size;
      e.ill = ill; e.full = full;
      return e;
   endfunction

   // Present one instruction on the ID port.
   task automatic drive(input logic [31:0] inst, input exp_t e);
      e.inst = inst; e.pc = pc_ctr; e.rd = inst[11:7];
      cur_exp = e; id_inst = inst; id_pc = pc_ctr; id_valid = 1'b1;
      pc_ctr += 32'd4;
   endtask

   // Wait (bounded) until the stage accepts the presented instruction.
   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (!id_ready && n < 20) begin @(negedge clk); n++; end
      check_eq("accept_timeout", 32'(id_ready), 32'd1);
      @(posedge clk); #1;
      id_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] inst, input exp_t e);
      drive(inst, e);
      wait_accept();
   endtask

   // Scoreboard: compare on EX consumption, enqueue on ID acceptance.
   always @(negedge clk) begin
      if (rstn) begin
         if (ex_valid && ex_ready) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               check_eq("pc", ex_pc, mon_e.pc);
               check_eq("inst", ex_inst, mon_e.inst);
               check_eq("rd", 32'(ex_rd), 32'(mon_e.rd));
               check_eq("wb_en", 32'(ex_wb_en), 32'(mon_e.wb));
               check_eq("wb_sel", 32'(ex_wb_sel), 32'(mon_e.wbsel));
               check_eq("br_type", 32'(ex_br_type), 32'(mon_e.br));
               check_eq("jal", 32'(ex_jal), 32'(mon_e.jal));
               check_eq("jalr", 32'(ex_jalr), 32'(mon_e.jalr));
               check_eq("mem_re", 32'(ex_mem_re), 32'(mon_e.mre));
               check_eq("mem_we", 32'(ex_mem_we), 32'(mon_e.mwe));
               check_eq("illegal", 32'(ex_illegal), 32'(mon_e.ill));
               if (mon_e.full) begin
                  check_eq("alu_ctrl", 32'(ex_alu_ctrl), 32'(mon_e.alu));
                  check_eq("op1_sel", 32'(ex_alu_op1_sel), 32'(mon_e.op1));
                  check_eq("op2_sel", 32'(ex_alu_op2_sel), 32'(mon_e.op2));
                  check_eq("imm_type", 32'(ex_imm_type), 32'(mon_e.imm));
                  if (mon_e.mre || mon_e.mwe)
                     check_eq("mem_size", 32'(ex_mem_size), 32'(mon_e.size));
               end
            end
         end
         if (id_valid && id_ready && !flush) sb_q.push_back(cur_exp);
      end
   end

   localparam logic [31:0] I_ADD  = 32'h002081B3;  // add x3,x1,x2
   localparam logic [31:0] I_LW   = 32'h0000A283;  // lw x5,0(x1)
   localparam logic [31:0] I_DEP  = 32'h00728333;  // add x6,x5,x7
   localparam logic [31:0] I_SW   = 32'h0020A423;  // sw x2,8(x1)
   localparam logic [31:0] I_MUL  = 32'h02208033;  // mul x0,x1,x2

   exp_t e_add, e_lw, e_sw, e_ill;
   logic [31:0] sw_pc;

   initial begin
      e_add = mk(5'd0, 1, 2'b00, 0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1);
      e_lw  = mk(5'd0, 1, 2'b10, 0, 1, 3'd1, 3'd0, 0, 0, 1, 0, 3'd2, 0, 1);
      e_sw  = mk(5'd0, 0, 2'b00, 0, 1, 3'd3, 3'd0, 0, 0, 0, 1, 3'd2, 0, 1);
      e_ill = mk(5'd0, 0, 2'b00, 0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 0);

      rstn = 1'b0; id_valid = 1'b0; id_inst = '0; id_pc = '0; ex_ready = 1'b1; flush = 1'b0;
      cur_exp = e_ill;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
      check_eq("rst_wb_en", 32'(ex_wb_en), 32'd0);
      check_eq("rst_alu_ctrl", 32'(ex_alu_ctrl), 32'd0);
      check_eq("rst_ex_pc", ex_pc, 32'd0);
      check_eq("rst_ill_cnt", 32'(illegal_cnt), 32'd0);
      check_eq("rst_stall", 32'(load_use_stall), 32'd0);
      rstn = 1'b1;

      // Basic add with ex_ready=1.
      send(I_ADD, e_add);
      check_eq("add_valid", 32'(ex_valid), 32'd1);
      check_eq("add_alu", 32'(ex_alu_ctrl), 32'd0);
      check_eq("add_re0", 32'(ex_rf_re0), 32'd1);
      check_eq("add_re1", 32'(ex_rf_re1), 32'd1);
      check_eq("add_wb", 32'(ex_wb_en), 32'd1);
      check_eq("add_rd", 32'(ex_rd), 32'd3);

      // Assorted legal decodes.
      send(32'h40208233, mk(5'd1, 1, 2'b00, 0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1)); // sub
      send(32'h4020D233, mk(5'd7, 1, 2'b00, 0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1)); // sra
      send(32'h0010C293, mk(5'd5, 1, 2'b00, 0, 1, 3'd1, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1)); // xori
      send(32'h4030D293, mk(5'd7, 1, 2'b00, 0, 1, 3'd1, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1)); // srai
      send(32'h000000EF, mk(5'd0, 1, 2'b01, 1, 1, 3'd4, 3'd0, 1, 0, 0, 0, 3'd0, 0, 1)); // jal x1
      send(32'h00008067, mk(5'd0, 0, 2'b01, 0, 1, 3'd1, 3'd0, 0, 1, 0, 0, 3'd0, 0, 1)); // jalr x0
      send(32'h123453B7, mk(5'd0, 1, 2'b11, 0, 0, 3'd5, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0)); // lui
      send(32'h00001417, mk(5'd0, 1, 2'b00, 1, 1, 3'd5, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1)); // auipc
      send(32'h0020F063, mk(5'd0, 0, 2'b00, 1, 1, 3'd2, 3'd6, 0, 0, 0, 0, 3'd0, 0, 1)); // bgeu

      // Illegal branch funct3 010: first illegal, counter goes to 1.
      send(32'h0020A063, e_ill);
      check_eq("bad_br_ill", 32'(ex_illegal), 32'd1);
      check_eq("ill_cnt_1", 32'(illegal_cnt), 32'd1);
      send(32'h40309293, e_ill);  // slli with bad funct7
`ifdef CTRL_RV32M_EN
      send(I_MUL, mk(5'd16, 0, 2'b00, 0, 0, 3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1));
`else
      send(I_MUL, e_ill);
`endif

      // Load-use: one stall cycle, one bubble, then the dependent add.
      send(I_LW, e_lw);
      drive(I_DEP, e_add);
      #1;
      check_eq("lu_stall", 32'(load_use_stall), 32'd1);
      check_eq("lu_id_ready", 32'(id_ready), 32'd0);
      @(posedge clk); #1;
      check_eq("lu_bubble", 32'(ex_valid), 32'd0);
      check_eq("lu_stall_clr", 32'(load_use_stall), 32'd0);
      wait_accept();
      check_eq("lu_dep_valid", 32'(ex_valid), 32'd1);
      check_eq("lu_dep_rd", 32'(ex_rd), 32'd6);

      // EX back-pressure with a store held for 3 cycles.
      sw_pc = pc_ctr;
      send(I_SW, e_sw);
      ex_ready = 1'b0;
      drive(I_ADD, e_add);
      repeat (3) begin
         @(posedge clk); #1;
         check_eq("hold_valid", 32'(ex_valid), 32'd1);
         check_eq("hold_inst", ex_inst, I_SW);
         check_eq("hold_pc", ex_pc, sw_pc);
         check_eq("hold_mem_we", 32'(ex_mem_we), 32'd1);
         check_eq("hold_id_ready", 32'(id_ready), 32'd0);
      end
      ex_ready = 1'b1;
      wait_accept();
      check_eq("hold_release", ex_inst, I_ADD);

      // Flush coinciding with a load-use hazard.
      send(I_LW, e_lw);
      drive(I_DEP, e_add);
      flush = 1'b1;
      #1;
      check_eq("fl_id_ready", 32'(id_ready), 32'd1);
      check_eq("fl_stall", 32'(load_use_stall), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; id_valid = 1'b0;
      check_eq("fl_valid", 32'(ex_valid), 32'd0);
      check_eq("fl_wb_en", 32'(ex_wb_en), 32'd0);
      check_eq("fl_mem_we", 32'(ex_mem_we), 32'd0);
      check_eq("fl_mem_re", 32'(ex_mem_re), 32'd0);

      // Stall persists under back-pressure; reset discards everything.
      send(I_LW, e_lw);
      ex_ready = 1'b0;
      drive(I_DEP, e_add);
      #1;
      check_eq("rs_stall", 32'(load_use_stall), 32'd1);
      @(posedge clk); #1;
      check_eq("rs_stall_hold", 32'(load_use_stall), 32'd1);
      check_eq("rs_inst_hold", ex_inst, I_LW);
      id_valid = 1'b0; rstn = 1'b0;
      sb_q.delete();
      @(posedge clk); #1;
      rstn = 1'b1; ex_ready = 1'b1;
      check_eq("rs_valid", 32'(ex_valid), 32'd0);
      check_eq("rs_stall_clr", 32'(load_use_stall), 32'd0);
      check_eq("rs_ill_cnt", 32'(illegal_cnt), 32'd0);

      // 256 illegal instructions saturate the counter at 255.
      for (int i = 0; i < 256; i++) send(32'h00000000, e_ill);
      check_eq("ill_cnt_sat", 32'(illegal_cnt), 32'd255);

      repeat (3) @(posedge clk);
      #1;
      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
